// File: rtl/yarp_ifetch_pkg.sv
// Shared types and helpers for the yarp instruction-fetch front end.
package yarp_ifetch_pkg;

    localparam int unsigned YARP_ADDR_W = 32;
    localparam int unsigned YARP_DATA_W = 32;

    typedef struct packed {
        logic [YARP_ADDR_W-1:0] pc;
        logic [YARP_DATA_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REQ_STALE
    } issue_state_t;

    function automatic logic [YARP_ADDR_W-1:0] pc_inc(input logic [YARP_ADDR_W-1:0] pc);
        return pc + YARP_ADDR_W'(4);
    endfunction

endpackage

// File: rtl/yarp_sync_fifo.sv
// Synchronous FIFO with flush; flush takes priority over push and pop.
module yarp_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (do_pop)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/yarp_ifetch_queue.sv
// Instruction-fetch front end: OBI-style issue with credit control, prefetch
// FIFO toward decode, and redirect handling that discards stale responses.
module yarp_ifetch_queue
    import yarp_ifetch_pkg::*;
#(
    parameter int unsigned       ADDR_W    = YARP_ADDR_W,
    parameter int unsigned       DATA_W    = YARP_DATA_W,
    parameter int unsigned       DEPTH     = 4,
    parameter int unsigned       MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o
);

    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned SH_CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTST);

    issue_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [CNT_W-1:0]  outst;
    logic [CNT_W-1:0]  discard;

    logic              granted;
    logic              rv_ok;
    logic              credit_ok;
    logic [CNT_W-1:0]  outst_nxt;
    logic [CNT_W-1:0]  discard_nxt;
    logic [CNT_W-1:0]  fifo_cnt_nxt;
    logic [ADDR_W-1:0] pc_after;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    fetch_entry_t      wr_entry;
    fetch_entry_t      rd_entry;

    logic [ADDR_W-1:0]   shadow_pc;
    logic                shadow_full;
    logic                shadow_empty;
    logic [SH_CNT_W-1:0] shadow_cnt;

    // Credit is checked against post-edge occupancy, so a grant and a new
    // issue can happen back to back without ever overrunning the FIFO.
    always_comb begin
        granted      = mem_req_o && mem_gnt_i;
        rv_ok        = mem_rvalid_i && (outst != '0);
        outst_nxt    = outst + CNT_W'(granted) - CNT_W'(rv_ok);
        fifo_push    = rv_ok && (discard == '0) && !redirect_i;
        fifo_pop     = instr_valid_o && instr_ready_i && !redirect_i;
        fifo_cnt_nxt = redirect_i ? '0 : fifo_cnt + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        credit_ok    = (({1'b0, outst_nxt} + {1'b0, fifo_cnt_nxt}) < DEPTH_C) &&
                       (outst_nxt < MAX_C);

        pc_after = fetch_pc;
        if (state == REQ && granted)
            pc_after = pc_inc(fetch_pc);
        if (redirect_i)
            pc_after = redirect_pc_i & ~ADDR_W'(3);

        // Every read still in flight after a redirect belongs to the old path.
        discard_nxt = discard - CNT_W'(rv_ok && (discard != '0))
                              + CNT_W'((state == REQ_STALE) && granted);
        if (redirect_i)
            discard_nxt = outst_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mem_req_o  <= 1'b0;
            mem_addr_o <= RESET_PC;
            fetch_pc   <= RESET_PC;
            outst      <= '0;
            discard    <= '0;
        end else begin
            fetch_pc <= pc_after;
            outst    <= outst_nxt;
            discard  <= discard_nxt;
            if (mem_req_o && !mem_gnt_i) begin
                // A request on the bus cannot be withdrawn; mark it stale instead.
                if (redirect_i)
                    state <= REQ_STALE;
            end else if (credit_ok) begin
                state      <= REQ;
                mem_req_o  <= 1'b1;
                mem_addr_o <= pc_after;
            end else begin
                state     <= IDLE;
                mem_req_o <= 1'b0;
            end
        end
    end

    yarp_sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTST)
    ) u_pc_shadow (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (granted),
        .pop     (rv_ok),
        .flush   (1'b0),
        .wdata   (mem_addr_o),
        .rdata   (shadow_pc),
        .full    (shadow_full),
        .empty   (shadow_empty),
        .count   (shadow_cnt)
    );

    assign wr_entry = '{pc: shadow_pc, instr: mem_rdata_i};

    yarp_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (redirect_i),
        .wdata   (wr_entry),
        .rdata   (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_cnt)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = instr_valid_o ? rd_entry.instr : '0;
    assign instr_pc_o    = instr_valid_o ? rd_entry.pc    : '0;

    a_rvalid_without_read: assert property (@(posedge clk) disable iff (!reset_n)
        !(mem_rvalid_i && (outst == '0)));
    a_shadow_tracks_outst: assert property (@(posedge clk) disable iff (!reset_n)
        CNT_W'(shadow_cnt) == outst);
    a_shadow_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(rv_ok && shadow_empty));
    a_shadow_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(granted && shadow_full && !rv_ok));
    a_fifo_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule
